// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one external combinational
//               ALU between two requesters. One operation is in flight at a
//               time. An accepted operation goes through IDLE -> EXEC -> RESP
//               and returns to IDLE once its owner takes the response.
// Ports       : clk_i/rst_i          clock, synchronous active-high reset
//               req_valid_i/ready_o  per-requester request handshake
//               reqN_src1/src2/ctrl  operands and control code of requester N
//               rsp_valid_o/ready_i  per-requester response handshake
//               rsp_result/zero_o    registered ALU result and zero flag
//               alu_src1/src2/ctrl_o latched operands driven to the ALU
//               alu_result/zero_i    combinational ALU outputs
//               busy_o, op_cnt_o     activity flag, completed-response count
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [WIDTH-1:0]  req0_src1_i,
    input  logic [WIDTH-1:0]  req0_src2_i,
    input  logic [WIDTH-1:0]  req1_src1_i,
    input  logic [WIDTH-1:0]  req1_src2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_result_o,
    output logic              rsp_zero_o,
    output logic [WIDTH-1:0]  alu_src1_o,
    output logic [WIDTH-1:0]  alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_result_i,
    input  logic              alu_zero_i,
    output logic              busy_o,
    output logic [7:0]        op_cnt_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_rr_ptr;
    logic              r_owner;
    logic [WIDTH-1:0]  r_src1;
    logic [WIDTH-1:0]  r_src2;
    logic [CTRL_W-1:0] r_ctrl;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic [7:0]        r_op_cnt;

    logic              w_any_valid;
    logic              w_winner;
    logic              w_rsp_done;

    assign w_any_valid = |req_valid_i;
    assign w_rsp_done  = (r_state == c_RESP) && rsp_ready_i[r_owner];

    // Contention goes to the preferred requester; a lone request wins
    // outright. With only bit 0 set, req_valid_i[1] is 0 which selects
    // requester 0, so the single-request case falls out of one bit.
    always_comb begin
        if (req_valid_i == 2'b11) begin
            w_winner = r_rr_ptr;
        end else begin
            w_winner = req_valid_i[1];
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_any_valid) w_next_state = c_EXEC;
            c_EXEC:  w_next_state = c_RESP;
            c_RESP:  if (w_rsp_done) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic. Ready is suppressed during reset so that no requester
    // believes it was accepted by an edge that reset overrides.
    always_comb begin
        req_ready_o = 2'b00;
        rsp_valid_o = 2'b00;
        if ((r_state == c_IDLE) && w_any_valid && !rst_i) begin
            req_ready_o[w_winner] = 1'b1;
        end
        if (r_state == c_RESP) begin
            rsp_valid_o[r_owner] = 1'b1;
        end
    end

    assign busy_o = (r_state != c_IDLE);

    // Datapath: operands latch only on the accept edge, so requester-side
    // changes while not accepted never reach the ALU.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_ctrl   <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_op_cnt <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_valid) begin
                        r_owner <= w_winner;
                        r_src1  <= w_winner ? req1_src1_i : req0_src1_i;
                        r_src2  <= w_winner ? req1_src2_i : req0_src2_i;
                        r_ctrl  <= w_winner ? req1_ctrl_i : req0_ctrl_i;
                    end
                end
                c_EXEC: begin
                    r_result <= alu_result_i;
                    r_zero   <= alu_zero_i;
                end
                c_RESP: begin
                    if (w_rsp_done) begin
                        r_rr_ptr <= ~r_owner;
                        r_op_cnt <= r_op_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_src1_o   = r_src1;
    assign alu_src2_o   = r_src2;
    assign alu_ctrl_o   = r_ctrl;
    assign rsp_result_o = r_result;
    assign rsp_zero_o   = r_zero;
    assign op_cnt_o     = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               behavioural ALU (2 add, 6 sub, 10 bne, others result 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [31:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
    logic [3:0]  req0_ctrl_i, req1_ctrl_i;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o;
    logic [31:0] alu_src1_o, alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        busy_o;
    logic [7:0]  op_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i),
        .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i),
        .req0_ctrl_i(req0_ctrl_i), .req1_ctrl_i(req1_ctrl_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .busy_o(busy_o), .op_cnt_o(op_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU; bne reports zero when operands differ (inverted sense).
    always_comb begin
        alu_result_i = 32'd0;
        alu_zero_i   = 1'b0;
        case (alu_ctrl_o)
            4'd2:  begin alu_result_i = alu_src1_o + alu_src2_o; alu_zero_i = (alu_result_i == 32'd0); end
            4'd6:  begin alu_result_i = alu_src1_o - alu_src2_o; alu_zero_i = (alu_result_i == 32'd0); end
            4'd10: begin alu_result_i = alu_src1_o - alu_src2_o; alu_zero_i = (alu_result_i != 32'd0); end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Stimulus only: runs one full operation for requester k and returns
    // what was observed along the way.
    task automatic run_op(input bit k, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, output logic [1:0] rdy,
                          output logic [3:0] ctrl_seen, output logic [1:0] vld,
                          output logic [31:0] res, output logic z);
        if (k) begin
            req1_src1_i = a; req1_src2_i = b; req1_ctrl_i = c; req_valid_i = 2'b10;
        end else begin
            req0_src1_i = a; req0_src2_i = b; req0_ctrl_i = c; req_valid_i = 2'b01;
        end
        #1;
        rdy = req_ready_o;
        tick();
        req_valid_i = 2'b00;
        ctrl_seen = alu_ctrl_o;
        tick();
        vld = rsp_valid_o;
        res = rsp_result_o;
        z   = rsp_zero_o;
        rsp_ready_i = k ? 2'b10 : 2'b01;
        tick();
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_reset();
        req_valid_i = 2'b11;
        rst_i = 1'b1;
        tick();
        tick();
        n_tests++;
        if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", req_ready_o); end
        n_tests++;
        if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_state rsp_valid %b busy %b exp 00/0", rsp_valid_o, busy_o);
        end
        n_tests++;
        if (rsp_result_o !== 32'd0 || rsp_zero_o !== 1'b0 || alu_src1_o !== 32'd0 ||
            alu_src2_o !== 32'd0 || alu_ctrl_o !== 4'd0 || op_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_regs res %h z %b s1 %h s2 %h c %h cnt %0d exp all 0",
                     rsp_result_o, rsp_zero_o, alu_src1_o, alu_src2_o, alu_ctrl_o, op_cnt_o);
        end
        req_valid_i = 2'b00;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0_src1_i = 32'd5; req0_src2_i = 32'd3; req0_ctrl_i = 4'd2;
        req_valid_i = 2'b01;
        #1;
        n_tests++;
        if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b exp 01", req_ready_o); end
        tick();
        req_valid_i = 2'b00;
        n_tests++;
        if (rsp_valid_o !== 2'b00 || busy_o !== 1'b1 || alu_src1_o !== 32'd5 ||
            alu_src2_o !== 32'd3 || alu_ctrl_o !== 4'd2) begin
            n_fail++;
            $display("FAIL single_exec vld %b busy %b s1 %0d s2 %0d c %0d exp 00/1/5/3/2",
                     rsp_valid_o, busy_o, alu_src1_o, alu_src2_o, alu_ctrl_o);
        end
        tick();
        n_tests++;
        if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd8 || rsp_zero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp vld %b res %0d z %b exp 01/8/0", rsp_valid_o, rsp_result_o, rsp_zero_o);
        end
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        n_tests++;
        if (op_cnt_o !== 8'd1 || rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done cnt %0d vld %b busy %b exp 1/00/0", op_cnt_o, rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_priority();
        do_reset();
        req0_src1_i = 32'd1; req0_src2_i = 32'd2; req0_ctrl_i = 4'd2;
        req1_src1_i = 32'd10; req1_src2_i = 32'd20; req1_ctrl_i = 4'd2;
        req_valid_i = 2'b11;
        #1;
        n_tests++;
        if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL prio_first got %b exp 01", req_ready_o); end
        tick();
        req_valid_i = 2'b10;
        tick();
        n_tests++;
        if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd3) begin
            n_fail++; $display("FAIL prio_rsp0 vld %b res %0d exp 01/3", rsp_valid_o, rsp_result_o);
        end
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        n_tests++;
        if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL prio_second got %b exp 10", req_ready_o); end
        tick();
        req_valid_i = 2'b00;
        tick();
        n_tests++;
        if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd30) begin
            n_fail++; $display("FAIL prio_rsp1 vld %b res %0d exp 10/30", rsp_valid_o, rsp_result_o);
        end
        rsp_ready_i = 2'b10;
        tick();
        rsp_ready_i = 2'b00;
        n_tests++;
        if (op_cnt_o !== 8'd2) begin n_fail++; $display("FAIL prio_cnt got %0d exp 2", op_cnt_o); end
    endtask

    task automatic test_alu_codes();
        logic [1:0] rdy, vld;
        logic [3:0] cs;
        logic [31:0] res;
        logic z;
        run_op(1'b1, 32'd7, 32'd7, 4'd10, rdy, cs, vld, res, z);
        n_tests++;
        if (rdy !== 2'b10 || vld !== 2'b10 || res !== 32'd0 || z !== 1'b0 || cs !== 4'd10) begin
            n_fail++; $display("FAIL code_bne rdy %b vld %b res %0d z %b c %0d exp 10/10/0/0/10", rdy, vld, res, z, cs);
        end
        run_op(1'b1, 32'd7, 32'd7, 4'd6, rdy, cs, vld, res, z);
        n_tests++;
        if (vld !== 2'b10 || res !== 32'd0 || z !== 1'b1) begin
            n_fail++; $display("FAIL code_sub vld %b res %0d z %b exp 10/0/1", vld, res, z);
        end
        run_op(1'b0, 32'd9, 32'd4, 4'd6, rdy, cs, vld, res, z);
        n_tests++;
        if (rdy !== 2'b01 || vld !== 2'b01 || res !== 32'd5 || z !== 1'b0) begin
            n_fail++; $display("FAIL code_sub5 rdy %b vld %b res %0d z %b exp 01/01/5/0", rdy, vld, res, z);
        end
        run_op(1'b0, 32'd3, 32'd4, 4'd15, rdy, cs, vld, res, z);
        n_tests++;
        if (cs !== 4'd15 || res !== 32'd0) begin
            n_fail++; $display("FAIL code_undef c %0d res %0d exp 15/0", cs, res);
        end
    endtask

    task automatic test_backpressure();
        req0_src1_i = 32'hFFFF_FFFF; req0_src2_i = 32'd1; req0_ctrl_i = 4'd2;
        req_valid_i = 2'b01;
        tick();
        req1_src1_i = 32'd40; req1_src2_i = 32'd2; req1_ctrl_i = 4'd6;
        req_valid_i = 2'b10;
        req0_src1_i = 32'd123;
        tick();
        for (int i = 0; i < 5; i++) begin
            rsp_ready_i = 2'b10;
            #1;
            n_tests++;
            if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd0 || rsp_zero_o !== 1'b1 ||
                busy_o !== 1'b1 || req_ready_o !== 2'b00 || alu_src1_o !== 32'hFFFF_FFFF) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d vld %b res %h z %b busy %b rdy %b s1 %h exp 01/0/1/1/00/ffffffff",
                         i, rsp_valid_o, rsp_result_o, rsp_zero_o, busy_o, req_ready_o, alu_src1_o);
            end
            tick();
        end
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        n_tests++;
        if (req_ready_o !== 2'b10 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_next rdy %b busy %b exp 10/0", req_ready_o, busy_o);
        end
        tick();
        req_valid_i = 2'b00;
        tick();
        n_tests++;
        if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd38) begin
            n_fail++; $display("FAIL bp_req1 vld %b res %0d exp 10/38", rsp_valid_o, rsp_result_o);
        end
        rsp_ready_i = 2'b10;
        tick();
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_reset_exec();
        req0_src1_i = 32'd5; req0_src2_i = 32'd6; req0_ctrl_i = 4'd2;
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00 || alu_src1_o !== 32'd0 || alu_src2_o !== 32'd0 ||
            alu_ctrl_o !== 4'd0 || op_cnt_o !== 8'd0 || rsp_result_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_exec busy %b vld %b s1 %h s2 %h c %h cnt %0d res %h exp all 0",
                     busy_o, rsp_valid_o, alu_src1_o, alu_src2_o, alu_ctrl_o, op_cnt_o, rsp_result_o);
        end
        rsp_ready_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (rsp_valid_o !== 2'b00 || op_cnt_o !== 8'd0) begin
                n_fail++; $display("FAIL rst_noresp cyc %0d vld %b cnt %0d exp 00/0", i, rsp_valid_o, op_cnt_o);
            end
        end
        rsp_ready_i = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        logic [7:0] exp_cnt;
        do_reset();
        req0_src1_i = 32'd1; req0_src2_i = 32'd1; req0_ctrl_i = 4'd2;
        req1_src1_i = 32'd2; req1_src2_i = 32'd2; req1_ctrl_i = 4'd2;
        req_valid_i = 2'b11;
        rsp_ready_i = 2'b11;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_tests++;
            if (req_ready_o !== exp_rdy || op_cnt_o !== exp_cnt) begin
                n_fail++; $display("FAIL b2b op %0d rdy %b cnt %0d exp %b/%0d", i, req_ready_o, op_cnt_o, exp_rdy, exp_cnt);
            end
            tick();
            tick();
            tick();
            exp_cnt = exp_cnt + 8'd1;
        end
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        #1;
        n_tests++;
        if (op_cnt_o !== 8'd0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_wrap cnt %0d busy %b exp 0/0", op_cnt_o, busy_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        req0_src1_i = '0; req0_src2_i = '0; req0_ctrl_i = '0;
        req1_src1_i = '0; req1_src2_i = '0; req1_ctrl_i = '0;
        #2;
        test_reset();
        test_single();
        test_priority();
        test_alu_codes();
        test_backpressure();
        test_reset_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width.
REQ-002 Parameter CTRL_W, default 4: ALU control code width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  2  per-requester request valid; bit k = requester k.
REQ-006 req_ready_o  output  2  per-requester accept strobe.
REQ-007 req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i  input  WIDTH each  operands.
REQ-008 req0_ctrl_i, req1_ctrl_i  input  CTRL_W each  ALU control code.
REQ-009 rsp_valid_o  output  2  per-requester response valid.
REQ-010 rsp_ready_i  input  2  per-requester response accept.
REQ-011 rsp_result_o  output  WIDTH  registered ALU result of the current response.
REQ-012 rsp_zero_o  output  1  registered ALU zero flag of the current response.
REQ-013 alu_src1_o, alu_src2_o  output  WIDTH each  operands to the shared ALU.
REQ-014 alu_ctrl_o  output  CTRL_W  control code to the shared ALU.
REQ-015 alu_result_i  input  WIDTH; alu_zero_i  input  1  combinational ALU outputs.
REQ-016 busy_o  output  1  high in any state other than IDLE.
REQ-017 op_cnt_o  output  8  count of completed responses.

Function
REQ-018 FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-019 Priority: rr_ptr (1 bit) names the preferred requester; when both bits of req_valid_i are high in IDLE, requester rr_ptr wins; when one is high, it wins regardless of rr_ptr.
REQ-020 IDLE: req_ready_o[winner] is high combinationally in the same cycle; all other ready bits stay low; outside IDLE req_ready_o = 2'b00.
REQ-021 Accept edge (IDLE, any valid): latch winner's src1/src2/ctrl into alu_src1_o/alu_src2_o/alu_ctrl_o registers, record owner, go to EXEC.
REQ-022 EXEC (one cycle): capture alu_result_i into rsp_result_o and alu_zero_i into rsp_zero_o, go to RESP.
REQ-023 RESP: rsp_valid_o[owner] high, other bit low; rsp_result_o/rsp_zero_o held stable.
REQ-024 RESP and rsp_ready_i[owner] high: go to IDLE, clear rsp_valid_o, rr_ptr <= ~owner, op_cnt_o <= op_cnt_o + 1 (wraps 255 -> 0); rsp_ready_i[~owner] ignored.
REQ-025 Latency: accept at edge N -> rsp_valid_o high from cycle N+2; peak throughput one op per 3 cycles.
REQ-026 ALU outputs held at latched values through EXEC and RESP; control codes forwarded unmodified, including codes the ALU does not define (ALU result 0 passes through).
REQ-027 zero flag passed through unmodified, including inverted sense of code 10 (bne).
REQ-028 Requester changing operands while not accepted has no effect; operands sampled only on accept edge.

Reset
REQ-029 rst_i high at an edge: state IDLE, rr_ptr 0, rsp_valid_o 0, rsp_result_o 0, rsp_zero_o 0, alu_src1_o/alu_src2_o/alu_ctrl_o 0, op_cnt_o 0; overrides all other transitions.
REQ-030 Reset in EXEC or RESP discards the in-flight op: no response, no count; req_ready_o 00 while rst_i high.

Verification
REQ-031 Req0 only, src 5/3 ctrl 2 -> ready0 at accept cycle N; rsp_valid_o=01 at N+2, result 8, zero 0; op_cnt 1 after rsp_ready0.
REQ-032 Both valid after reset, req1 held -> req0 served first (ready 01), then req1 (ready 10) in next IDLE; op_cnt 2.
REQ-033 Req1 src 7/7 ctrl 10 -> result 0, zero 0; ctrl 6 same operands -> result 0, zero 1.
REQ-034 Req0 ctrl 2 0xFFFFFFFF+1, rsp_ready0 low 5 cycles while req1 valid -> rsp_valid 01 held, result 0, zero 1, busy 1, ready 00 throughout; req1 accepted in IDLE after handshake.
REQ-035 rst_i pulsed in EXEC -> next cycle state IDLE, rsp_valid 00, alu_* 0, op_cnt 0, no response ever issued.
REQ-036 256 back-to-back ops alternating requesters -> grants alternate strictly, op_cnt_o 255 then wraps to 0.
